fetch_unit: RTL and testbench

Parametrised instruction fetch stage that replaces the single-width program counter.
- Drives a synchronous-read instruction memory (one-cycle read latency, external to this block).
- Presents one instruction per cycle with an explicit valid flag instead of masking.
- Supports stall, jump, call and return; call/return use an internal return-address stack.
- Sits between instruction memory and the decoder; the decoder issues all redirect commands.

---
 rtl/fetch_unit.sv | 174 +++++++++++++++++
 tb/tb_fetch_unit.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives a one-cycle-latency instruction memory,
// presents one instruction per cycle with a valid flag, and handles stall,
// jump, call and return through an internal return-address stack.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_stall            decoder holds the current instruction
//   i_jump/i_call/i_ret redirect commands (priority jump > call > ret)
//   i_target           jump/call destination
//   o_mem_addr         registered fetch address to memory
//   i_mem_data         memory data for the address sampled at the previous edge
//   o_instr, o_pc      current instruction and its address
//   o_valid            o_instr/o_pc are meaningful
//   o_stack_fault      sticky return-stack overflow/underflow flag
module fetch_unit #(
    parameter int unsigned              ADDR_WIDTH   = 8,
    parameter int unsigned              INSTR_WIDTH  = 16,
    parameter int unsigned              STACK_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0]    RESET_ADDR   = '0,
    parameter logic [INSTR_WIDTH-1:0]   BUBBLE_INSTR = '1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic                   i_jump,
    input  logic                   i_call,
    input  logic                   i_ret,
    input  logic [ADDR_WIDTH-1:0]  i_target,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic [INSTR_WIDTH-1:0] i_mem_data,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic                   o_valid,
    output logic                   o_stack_fault
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // FILL: waiting for memory data (bubble); RUN: streaming;
    // STALL: held, instruction served from the hold register.
    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    mem_addr_q;
    logic [ADDR_WIDTH-1:0]    pc_q;
    logic [INSTR_WIDTH-1:0]   hold_q;
    logic [ADDR_WIDTH-1:0]    stack_q [STACK_DEPTH];
    logic [SP_W-1:0]          sp_q;
    logic                     fault_q;

    logic                     accept;
    logic                     do_jump, do_call, do_ret;
    logic                     redirect, advance;
    logic                     stack_full, stack_empty;
    logic [ADDR_WIDTH-1:0]    stack_top;
    logic [ADDR_WIDTH-1:0]    dest;

    // Command decode: only the highest-priority accepted command acts.
    always_comb begin
        accept      = (state_q != S_FILL) && !i_stall;
        do_jump     = accept && i_jump;
        do_call     = accept && !i_jump && i_call;
        do_ret      = accept && !i_jump && !i_call && i_ret;
        redirect    = do_jump || do_call || do_ret;
        advance     = (state_q == S_FILL) || (accept && !redirect);
        stack_full  = (sp_q == SP_W'(STACK_DEPTH));
        stack_empty = (sp_q == '0);
        stack_top   = stack_q[IDX_W'(sp_q - SP_W'(1))];
        dest        = i_target;
        if (do_ret) begin
            dest = stack_empty ? RESET_ADDR : stack_top;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a stall outranks any command.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: state_d = S_RUN;
            S_RUN, S_STALL: begin
                if (i_stall) begin
                    state_d = S_STALL;
                end else if (redirect) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // Output decode: in STALL the memory already shows the next word,
    // so the held instruction comes from the hold register.
    always_comb begin
        o_valid = 1'b0;
        o_instr = BUBBLE_INSTR;
        case (state_q)
            S_RUN: begin
                o_valid = 1'b1;
                o_instr = i_mem_data;
            end
            S_STALL: begin
                o_valid = 1'b1;
                o_instr = hold_q;
            end
            default: begin
                o_valid = 1'b0;
                o_instr = BUBBLE_INSTR;
            end
        endcase
    end

    // Fetch address, PC, hold register, return stack and fault flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mem_addr_q <= RESET_ADDR;
            pc_q       <= RESET_ADDR;
            hold_q     <= BUBBLE_INSTR;
            sp_q       <= '0;
            fault_q    <= 1'b0;
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            if (redirect) begin
                mem_addr_q <= dest;
            end else if (advance) begin
                mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
            end

            if (advance) begin
                pc_q <= mem_addr_q;
            end

            // Capture only on the first stalled edge, before the data bus moves on.
            if ((state_q == S_RUN) && i_stall) begin
                hold_q <= i_mem_data;
            end

            if (do_call && !stack_full) begin
                stack_q[IDX_W'(sp_q)] <= pc_q + ADDR_WIDTH'(1);
                sp_q                  <= sp_q + SP_W'(1);
            end

            if (do_ret && !stack_empty) begin
                sp_q <= sp_q - SP_W'(1);
            end

            if ((do_call && stack_full) || (do_ret && stack_empty)) begin
                fault_q <= 1'b1;
            end
        end
    end

    assign o_mem_addr    = mem_addr_q;
    assign o_pc          = pc_q;
    assign o_stack_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    typedef struct packed {
        logic        valid;
        logic [7:0]  pc;
        logic [15:0] instr;
        logic        fault;
    } exp_t;

    typedef struct packed {
        logic       stall;
        logic       jump;
        logic       call;
        logic       ret;
        logic [7:0] target;
        exp_t       e;
    } step_t;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_stall, i_jump, i_call, i_ret;
    logic [7:0]  i_target;
    logic [7:0]  o_mem_addr;
    logic [15:0] i_mem_data;
    logic [15:0] o_instr;
    logic [7:0]  o_pc;
    logic        o_valid;
    logic        o_stack_fault;

    int n_cmp = 0;
    int n_bad = 0;

    step_t stim_q [$];
    exp_t  exp_q  [$];

    fetch_unit dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_jump       (i_jump),
        .i_call       (i_call),
        .i_ret        (i_ret),
        .i_target     (i_target),
        .o_mem_addr   (o_mem_addr),
        .i_mem_data   (i_mem_data),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_valid      (o_valid),
        .o_stack_fault(o_stack_fault)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Synchronous-read memory, mem[i] = 16'h1000 + i.
    always @(posedge i_clk) i_mem_data <= 16'h1000 + 16'(o_mem_addr);

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion before 200000");
        $fatal(1, "timeout");
    end

    function automatic exp_t e(input logic v, input logic [7:0] pc, input logic f);
        exp_t r;
        r.valid = v;
        r.pc    = pc;
        r.instr = v ? (16'h1000 + 16'(pc)) : 16'hFFFF;
        r.fault = f;
        return r;
    endfunction

    task automatic plan(input logic st, input logic jp, input logic cl, input logic rt,
                        input logic [7:0] tg, input exp_t ex);
        step_t s;
        s.stall = st; s.jump = jp; s.call = cl; s.ret = rt; s.target = tg; s.e = ex;
        stim_q.push_back(s);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_idle();
        i_stall = 1'b0; i_jump = 1'b0; i_call = 1'b0; i_ret = 1'b0; i_target = 8'h00;
    endtask

    task automatic do_reset();
        drive_idle();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        stim_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        drive_idle();
        i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        n_cmp++; if (o_valid !== 1'b0)        begin n_bad++; $display("FAIL reset valid: got %0b exp 0", o_valid); end
        n_cmp++; if (o_pc !== 8'h00)          begin n_bad++; $display("FAIL reset pc: got %h exp 00", o_pc); end
        n_cmp++; if (o_instr !== 16'hFFFF)    begin n_bad++; $display("FAIL reset instr: got %h exp ffff", o_instr); end
        n_cmp++; if (o_mem_addr !== 8'h00)    begin n_bad++; $display("FAIL reset mem_addr: got %h exp 00", o_mem_addr); end
        n_cmp++; if (o_stack_fault !== 1'b0)  begin n_bad++; $display("FAIL reset fault: got %0b exp 0", o_stack_fault); end
    endtask

    task automatic test_run();
        step_t s; exp_t ex, got; int k;
        do_reset();
        for (int i = 0; i < 10; i++) plan(0, 0, 0, 0, 8'h00, e(1, 8'(i), 0));
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            i_stall = s.stall; i_jump = s.jump; i_call = s.call; i_ret = s.ret; i_target = s.target;
            exp_q.push_back(s.e);
            tick();
            ex = exp_q.pop_front();
            got = {o_valid, o_pc, o_instr, o_stack_fault};
            if (!ex.valid) got.pc = ex.pc;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL run step %0d: got v=%0b pc=%h instr=%h fault=%0b, exp v=%0b pc=%h instr=%h fault=%0b",
                         k, got.valid, got.pc, got.instr, got.fault, ex.valid, ex.pc, ex.instr, ex.fault);
            end
            k++;
        end
    endtask

    task automatic test_stall();
        step_t s; exp_t ex, got; int k;
        do_reset();
        for (int i = 0; i <= 5; i++) plan(0, 0, 0, 0, 8'h00, e(1, 8'(i), 0));
        // Commands raised during a stall must be ignored.
        plan(1, 0, 0, 0, 8'h00, e(1, 8'h05, 0));
        plan(1, 1, 0, 0, 8'h80, e(1, 8'h05, 0));
        plan(1, 0, 1, 0, 8'h90, e(1, 8'h05, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h06, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h07, 0));
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            i_stall = s.stall; i_jump = s.jump; i_call = s.call; i_ret = s.ret; i_target = s.target;
            exp_q.push_back(s.e);
            tick();
            ex = exp_q.pop_front();
            got = {o_valid, o_pc, o_instr, o_stack_fault};
            if (!ex.valid) got.pc = ex.pc;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL stall step %0d: got v=%0b pc=%h instr=%h fault=%0b, exp v=%0b pc=%h instr=%h fault=%0b",
                         k, got.valid, got.pc, got.instr, got.fault, ex.valid, ex.pc, ex.instr, ex.fault);
            end
            if (s.stall) begin
                n_cmp++;
                if (o_mem_addr !== 8'h06) begin
                    n_bad++;
                    $display("FAIL stall mem_addr step %0d: got %h exp 06", k, o_mem_addr);
                end
            end
            k++;
        end
    endtask

    task automatic test_jump();
        step_t s; exp_t ex, got; int k;
        do_reset();
        for (int i = 0; i <= 3; i++) plan(0, 0, 0, 0, 8'h00, e(1, 8'(i), 0));
        plan(0, 1, 0, 0, 8'h40, e(0, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h40, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h41, 0));
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            i_stall = s.stall; i_jump = s.jump; i_call = s.call; i_ret = s.ret; i_target = s.target;
            exp_q.push_back(s.e);
            tick();
            ex = exp_q.pop_front();
            got = {o_valid, o_pc, o_instr, o_stack_fault};
            if (!ex.valid) got.pc = ex.pc;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL jump step %0d: got v=%0b pc=%h instr=%h fault=%0b, exp v=%0b pc=%h instr=%h fault=%0b",
                         k, got.valid, got.pc, got.instr, got.fault, ex.valid, ex.pc, ex.instr, ex.fault);
            end
            k++;
        end
    endtask

    task automatic test_call_ret();
        step_t s; exp_t ex, got; int k;
        do_reset();
        for (int i = 0; i <= 2; i++) plan(0, 0, 0, 0, 8'h00, e(1, 8'(i), 0));
        plan(0, 0, 1, 0, 8'h20, e(0, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h20, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h21, 0));
        plan(0, 0, 1, 0, 8'h30, e(0, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h30, 0));
        // Jump beats ret; the stack must keep both entries.
        plan(0, 1, 0, 1, 8'h35, e(0, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h35, 0));
        plan(0, 0, 0, 1, 8'h00, e(0, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h22, 0));
        plan(0, 0, 0, 1, 8'h00, e(0, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h03, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h04, 0));
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            i_stall = s.stall; i_jump = s.jump; i_call = s.call; i_ret = s.ret; i_target = s.target;
            exp_q.push_back(s.e);
            tick();
            ex = exp_q.pop_front();
            got = {o_valid, o_pc, o_instr, o_stack_fault};
            if (!ex.valid) got.pc = ex.pc;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL call_ret step %0d: got v=%0b pc=%h instr=%h fault=%0b, exp v=%0b pc=%h instr=%h fault=%0b",
                         k, got.valid, got.pc, got.instr, got.fault, ex.valid, ex.pc, ex.instr, ex.fault);
            end
            k++;
        end
    endtask

    task automatic test_faults();
        step_t s; exp_t ex, got; int k;
        logic [7:0] t;
        do_reset();
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h00, 0));
        for (int i = 0; i < 5; i++) begin
            t = 8'h10 * 8'(i + 1);
            plan(0, 0, 1, 0, t, e(0, 8'h00, (i == 4)));
            plan(0, 0, 0, 0, 8'h00, e(1, t, (i == 4)));
        end
        // Fifth push was discarded, so the top is still the fourth return address.
        plan(0, 0, 0, 1, 8'h00, e(0, 8'h00, 1));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h31, 1));
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            i_stall = s.stall; i_jump = s.jump; i_call = s.call; i_ret = s.ret; i_target = s.target;
            exp_q.push_back(s.e);
            tick();
            ex = exp_q.pop_front();
            got = {o_valid, o_pc, o_instr, o_stack_fault};
            if (!ex.valid) got.pc = ex.pc;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL overflow step %0d: got v=%0b pc=%h instr=%h fault=%0b, exp v=%0b pc=%h instr=%h fault=%0b",
                         k, got.valid, got.pc, got.instr, got.fault, ex.valid, ex.pc, ex.instr, ex.fault);
            end
            k++;
        end

        do_reset();
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h00, 0));
        plan(0, 0, 0, 1, 8'h00, e(0, 8'h00, 1));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h00, 1));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h01, 1));
        plan(1, 0, 0, 0, 8'h00, e(1, 8'h01, 1));
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            i_stall = s.stall; i_jump = s.jump; i_call = s.call; i_ret = s.ret; i_target = s.target;
            exp_q.push_back(s.e);
            tick();
            ex = exp_q.pop_front();
            got = {o_valid, o_pc, o_instr, o_stack_fault};
            if (!ex.valid) got.pc = ex.pc;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL underflow step %0d: got v=%0b pc=%h instr=%h fault=%0b, exp v=%0b pc=%h instr=%h fault=%0b",
                         k, got.valid, got.pc, got.instr, got.fault, ex.valid, ex.pc, ex.instr, ex.fault);
            end
            k++;
        end
    endtask

    // Continues from the stalled, faulted state left by test_faults.
    task automatic test_async_reset();
        step_t s; exp_t ex, got; int k;
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0)       begin n_bad++; $display("FAIL async_rst valid: got %0b exp 0", o_valid); end
        n_cmp++; if (o_pc !== 8'h00)         begin n_bad++; $display("FAIL async_rst pc: got %h exp 00", o_pc); end
        n_cmp++; if (o_instr !== 16'hFFFF)   begin n_bad++; $display("FAIL async_rst instr: got %h exp ffff", o_instr); end
        n_cmp++; if (o_mem_addr !== 8'h00)   begin n_bad++; $display("FAIL async_rst mem_addr: got %h exp 00", o_mem_addr); end
        n_cmp++; if (o_stack_fault !== 1'b0) begin n_bad++; $display("FAIL async_rst fault: got %0b exp 0", o_stack_fault); end
        drive_idle();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        // Jump during the fill bubble must be ignored.
        plan(0, 1, 0, 0, 8'h40, e(1, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h01, 0));
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            i_stall = s.stall; i_jump = s.jump; i_call = s.call; i_ret = s.ret; i_target = s.target;
            exp_q.push_back(s.e);
            tick();
            ex = exp_q.pop_front();
            got = {o_valid, o_pc, o_instr, o_stack_fault};
            if (!ex.valid) got.pc = ex.pc;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL fill_ignore step %0d: got v=%0b pc=%h instr=%h fault=%0b, exp v=%0b pc=%h instr=%h fault=%0b",
                         k, got.valid, got.pc, got.instr, got.fault, ex.valid, ex.pc, ex.instr, ex.fault);
            end
            k++;
        end
    endtask

    task automatic test_wrap();
        step_t s; exp_t ex, got; int k;
        do_reset();
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h00, 0));
        plan(0, 1, 0, 0, 8'hFD, e(0, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'hFD, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'hFE, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'hFF, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h00, 0));
        plan(0, 0, 0, 0, 8'h00, e(1, 8'h01, 0));
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            i_stall = s.stall; i_jump = s.jump; i_call = s.call; i_ret = s.ret; i_target = s.target;
            exp_q.push_back(s.e);
            tick();
            ex = exp_q.pop_front();
            got = {o_valid, o_pc, o_instr, o_stack_fault};
            if (!ex.valid) got.pc = ex.pc;
            n_cmp++;
            if (got !== ex) begin
                n_bad++;
                $display("FAIL wrap step %0d: got v=%0b pc=%h instr=%h fault=%0b, exp v=%0b pc=%h instr=%h fault=%0b",
                         k, got.valid, got.pc, got.instr, got.fault, ex.valid, ex.pc, ex.instr, ex.fault);
            end
            k++;
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        drive_idle();
        test_reset();
        test_run();
        test_stall();
        test_jump();
        test_call_ret();
        test_faults();
        test_async_reset();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
